// File: rtl/mem_op_pkg.sv
// Shared opcode encodings (instruction bits 15:9) and sequencer state type.
// The data-memory decoder imports the same opcode constants.
package mem_op_pkg;

  // LDM/STM are matched on their top five bits; the low bits name the base register.
  localparam logic [4:0] OP_STM_HI = 5'b1100_0;
  localparam logic [4:0] OP_LDM_HI = 5'b1100_1;
  localparam logic [6:0] OP_PUSH   = 7'b1011_010;
  localparam logic [6:0] OP_POP    = 7'b1011_110;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_TAIL = 2'd2,
    S_DONE = 2'd3
  } seq_state_t;

  // Number of registers named by a 9-bit list.
  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 9; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/lowest_set_bit.sv
// 9-bit priority encoder: index of the lowest set bit and a valid flag.
module lowest_set_bit (
  input  logic [8:0] i_bits,
  output logic [3:0] o_idx,
  output logic       o_valid
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 8; i >= 0; i--) begin
      if (i_bits[i]) begin
        o_idx   = 4'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM/PUSH/POP beat sequencer: one memory beat per listed register,
// lowest register first, then an optional base-register writeback.
// Optional macro SEQ_STALL_EN adds a stall input that freezes the sequencer
// and blanks the strobes (mem_write_en, rf_write_en, wb_en, done).
// Handshake: start is sampled only in IDLE; busy is high from the cycle after
// acceptance through the done cycle; done is a single-cycle pulse.
module ldm_stm_sequencer
  import mem_op_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [6:0]        opCode,
  input  logic [8:0]        reg_list,
  input  logic [ADDR_W-1:0] base_val,
`ifdef SEQ_STALL_EN
  input  logic              stall,
`endif
  output logic              busy,
  output logic              mem_write_en,
  output logic [6:0]        mem_opCode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        st_reg,
  output logic              rf_write_en,
  output logic [3:0]        rf_waddr,
  output logic              wb_en,
  output logic [3:0]        wb_reg,
  output logic [ADDR_W-1:0] wb_val,
  output logic              done,
  output seq_state_t        dbg_state
);

  seq_state_t        r_state, w_state_next;
  logic [6:0]        r_op;
  logic [8:0]        r_list;
  logic [ADDR_W-1:0] r_addr;
  logic              r_is_load;
  logic [3:0]        r_hi_reg;
  logic              r_wb_ok;
  logic [3:0]        r_wb_reg;
  logic [ADDR_W-1:0] r_wb_val;
  logic              r_rf_we;
  logic [3:0]        r_rf_waddr;

  logic              w_stall;
  logic              w_is_stm, w_is_ldm, w_is_push, w_is_pop, w_accept;
  logic [8:0]        w_eff_list, w_list_next;
  logic [3:0]        w_n, w_idx, w_cur_reg;
  logic              w_valid, w_last;
  logic [ADDR_W-1:0] w_four_n;

`ifdef SEQ_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  assign w_is_stm  = (opCode[6:2] == OP_STM_HI);
  assign w_is_ldm  = (opCode[6:2] == OP_LDM_HI);
  assign w_is_push = (opCode == OP_PUSH);
  assign w_is_pop  = (opCode == OP_POP);
  assign w_accept  = (r_state == S_IDLE) && start && !w_stall &&
                     (w_is_stm || w_is_ldm || w_is_push || w_is_pop);

  // Bit 8 only means something for PUSH (LR) and POP (PC).
  assign w_eff_list = (w_is_push || w_is_pop) ? reg_list : {1'b0, reg_list[7:0]};
  assign w_n        = popcount9(w_eff_list);
  assign w_four_n   = ADDR_W'({w_n, 2'b00});

  lowest_set_bit u_lsb (
    .i_bits  (r_list),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_cur_reg   = (w_idx == 4'd8) ? r_hi_reg : w_idx;
  assign w_list_next = r_list & ~(9'd1 << w_idx);
  assign w_last      = !w_valid || (w_list_next == 9'd0);

  assign rf_write_en = r_rf_we && !w_stall;
  assign rf_waddr    = r_rf_waddr;
  assign dbg_state   = r_state;

  // State register; stall holds the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else if (!w_stall) r_state <= w_state_next;
  end

  // Next-state decode and per-state outputs.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    mem_write_en = 1'b0;
    mem_opCode   = '0;
    mem_addr     = '0;
    st_reg       = '0;
    done         = 1'b0;
    wb_en        = 1'b0;
    wb_reg       = '0;
    wb_val       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = (w_eff_list == 9'd0) ? S_DONE : S_XFER;
      end
      S_XFER: begin
        busy       = 1'b1;
        mem_opCode = r_op;
        mem_addr   = r_addr;
        if (!r_is_load) begin
          mem_write_en = !w_stall;
          st_reg       = w_cur_reg;
        end
        if (w_last) w_state_next = r_is_load ? S_TAIL : S_DONE;
      end
      S_TAIL: begin
        busy         = 1'b1;
        mem_opCode   = r_op;
        w_state_next = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        mem_opCode   = r_op;
        done         = !w_stall;
        if (r_wb_ok) begin
          wb_en  = !w_stall;
          wb_reg = r_wb_reg;
          wb_val = r_wb_val;
        end
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: latch the request, walk the list, delay load writes by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= '0;
      r_list     <= '0;
      r_addr     <= '0;
      r_is_load  <= 1'b0;
      r_hi_reg   <= '0;
      r_wb_ok    <= 1'b0;
      r_wb_reg   <= '0;
      r_wb_val   <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
    end else if (!w_stall) begin
      case (r_state)
        S_IDLE: begin
          r_rf_we    <= 1'b0;
          r_rf_waddr <= '0;
          if (w_accept) begin
            r_op      <= opCode;
            r_list    <= w_eff_list;
            r_addr    <= w_is_push ? (base_val - w_four_n) : base_val;
            r_is_load <= w_is_ldm || w_is_pop;
            r_hi_reg  <= w_is_pop ? REG_PC : REG_LR;
            r_wb_reg  <= (w_is_push || w_is_pop) ? REG_SP : {1'b0, opCode[2:0]};
            r_wb_val  <= w_is_push ? (base_val - w_four_n) : (base_val + w_four_n);
            // LDM that reloads its own base keeps the loaded value.
            r_wb_ok   <= (w_n != 4'd0) && !(w_is_ldm && reg_list[opCode[2:0]]);
          end
        end
        S_XFER: begin
          r_list     <= w_list_next;
          r_addr     <= r_addr + ADDR_W'(4);
          r_rf_we    <= r_is_load;
          r_rf_waddr <= r_is_load ? w_cur_reg : 4'd0;
        end
        default: begin
          r_rf_we    <= 1'b0;
          r_rf_waddr <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer: a table of transfers with hand-computed
// beats and writebacks, plus hand sequences for rejection, busy-start and reset.
module tb_ldm_stm_sequencer;
  import mem_op_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [6:0]  opCode = '0;
  logic [8:0]  reg_list = '0;
  logic [31:0] base_val = '0;
  logic        busy, mem_write_en, rf_write_en, wb_en, done;
  logic [6:0]  mem_opCode;
  logic [31:0] mem_addr, wb_val;
  logic [3:0]  st_reg, rf_waddr, wb_reg;
  seq_state_t  dbg_state;
`ifdef SEQ_STALL_EN
  logic        stall = 1'b0;
`endif

  ldm_stm_sequencer #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .opCode       (opCode),
    .reg_list     (reg_list),
    .base_val     (base_val),
`ifdef SEQ_STALL_EN
    .stall        (stall),
`endif
    .busy         (busy),
    .mem_write_en (mem_write_en),
    .mem_opCode   (mem_opCode),
    .mem_addr     (mem_addr),
    .st_reg       (st_reg),
    .rf_write_en  (rf_write_en),
    .rf_waddr     (rf_waddr),
    .wb_en        (wb_en),
    .wb_reg       (wb_reg),
    .wb_val       (wb_val),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // One transfer: inputs plus expected beats (regs holds beat i in nibble i).
  typedef struct {
    logic [6:0]  op;
    logic [8:0]  list;
    logic [31:0] base;
    int          n;
    logic        is_load;
    logic [35:0] regs;
    logic [31:0] addr0;
    logic        wb;
    logic [3:0]  wb_reg;
    logic [31:0] wb_val;
    logic        poke;
  } vec_t;

  int n_checks = 0;
  int n_err = 0;

  // Scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] nib_of(input logic [35:0] r, input int i);
    return r[4*i +: 4];
  endfunction

  function automatic vec_t mk(input logic [6:0] op, input logic [8:0] list, input logic [31:0] base,
                              input int n, input logic ld, input logic [35:0] regs,
                              input logic [31:0] addr0, input logic wb, input logic [3:0] wr,
                              input logic [31:0] wv, input logic poke);
    vec_t v;
    v.op = op; v.list = list; v.base = base; v.n = n; v.is_load = ld; v.regs = regs;
    v.addr0 = addr0; v.wb = wb; v.wb_reg = wr; v.wb_val = wv; v.poke = poke;
    return v;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " mem_we"}, 64'(mem_write_en), 64'd0);
    chk({tag, " mem_op"}, 64'(mem_opCode), 64'd0);
    chk({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, " st_reg"}, 64'(st_reg), 64'd0);
    chk({tag, " rf_we"}, 64'(rf_write_en), 64'd0);
    chk({tag, " wb_en"}, 64'(wb_en), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " state"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  // Driver: called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic run_vec(input int k, input vec_t v);
    int lat;
    logic beat, rfw, fin;
    string t;
    lat = (v.n == 0) ? 1 : (v.is_load ? v.n + 2 : v.n + 1);
    start = 1'b1; opCode = v.op; reg_list = v.list; base_val = v.base;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      t    = $sformatf("v%0d c%0d", k, c);
      beat = (c <= v.n);
      rfw  = v.is_load && (c >= 2) && (c <= v.n + 1);
      fin  = (c == lat);
      chk({t, " busy"}, 64'(busy), 64'd1);
      chk({t, " mem_op"}, 64'(mem_opCode), 64'(v.op));
      chk({t, " mem_we"}, 64'(mem_write_en), 64'(beat && !v.is_load));
      chk({t, " mem_addr"}, 64'(mem_addr), beat ? 64'(v.addr0 + 32'(4 * (c - 1))) : 64'd0);
      chk({t, " st_reg"}, 64'(st_reg), (beat && !v.is_load) ? 64'(nib_of(v.regs, c - 1)) : 64'd0);
      chk({t, " rf_we"}, 64'(rf_write_en), 64'(rfw));
      chk({t, " rf_waddr"}, 64'(rf_waddr), rfw ? 64'(nib_of(v.regs, c - 2)) : 64'd0);
      chk({t, " done"}, 64'(done), 64'(fin));
      chk({t, " wb_en"}, 64'(wb_en), 64'(fin && v.wb));
      chk({t, " wb_reg"}, 64'(wb_reg), (fin && v.wb) ? 64'(v.wb_reg) : 64'd0);
      chk({t, " wb_val"}, 64'(wb_val), (fin && v.wb) ? 64'(v.wb_val) : 64'd0);
      chk({t, " state"}, 64'(dbg_state), fin ? 64'(S_DONE) : (beat ? 64'(S_XFER) : 64'(S_TAIL)));
      // A second start while busy, with different operands, must be ignored.
      if (v.poke && c == 1) begin
        start = 1'b1; opCode = OP_POP; reg_list = 9'h1FF; base_val = 32'h0;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk_idle($sformatf("v%0d post", k));
  endtask

  vec_t vecs[10];

  initial begin
    // STM R2, {R1,R3}
    vecs[0] = mk(7'b1100_010, 9'h00A, 32'h100, 2, 1'b0, 36'h31, 32'h100, 1'b1, 4'd2, 32'h108, 1'b0);
    // PUSH {R0,LR}
    vecs[1] = mk(OP_PUSH, 9'h101, 32'h200, 2, 1'b0, 36'hE0, 32'h1F8, 1'b1, 4'd13, 32'h1F8, 1'b0);
    // LDM R5, {R0,R1}: base not in list, writes back
    vecs[2] = mk(7'b1100_101, 9'h003, 32'h40, 2, 1'b1, 36'h10, 32'h40, 1'b1, 4'd5, 32'h48, 1'b0);
    // LDM R4, {R0,R1,R4}: base in list, no writeback
    vecs[3] = mk(7'b1100_100, 9'h013, 32'h40, 3, 1'b1, 36'h410, 32'h40, 1'b0, 4'd0, 32'h0, 1'b0);
    // POP {PC} with SP wrapping to zero
    vecs[4] = mk(OP_POP, 9'h100, 32'hFFFF_FFFC, 1, 1'b1, 36'hF, 32'hFFFF_FFFC, 1'b1, 4'd13, 32'h0, 1'b0);
    // STM empty list
    vecs[5] = mk(7'b1100_001, 9'h000, 32'h500, 0, 1'b0, 36'h0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0);
    // STM with only bit 8 set: bit 8 ignored, so empty
    vecs[6] = mk(7'b1100_011, 9'h100, 32'h500, 0, 1'b0, 36'h0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0);
    // STM R3, {R0..R7}: base in list still writes back for stores
    vecs[7] = mk(7'b1100_011, 9'h0FF, 32'h1000, 8, 1'b0, 36'h76543210, 32'h1000, 1'b1, 4'd3, 32'h1020, 1'b0);
    // PUSH all nine
    vecs[8] = mk(OP_PUSH, 9'h1FF, 32'h100, 9, 1'b0, 36'hE76543210, 32'hDC, 1'b1, 4'd13, 32'hDC, 1'b0);
    // STM R0, {R1,R2} with an ignored start while busy
    vecs[9] = mk(7'b1100_000, 9'h006, 32'h20, 2, 1'b0, 36'h21, 32'h20, 1'b1, 4'd0, 32'h28, 1'b1);

    // Outputs are quiet while reset is held
    repeat (2) @(negedge clk);
    chk_idle("reset");

    // Start on the first edge after reset release
    rst = 1'b0;
    run_vec(0, vecs[0]);
    for (int k = 1; k < 10; k++) run_vec(k, vecs[k]);

    // Unsupported opcodes are ignored
    start = 1'b1; opCode = 7'b0000_000; reg_list = 9'h0FF; base_val = 32'h80;
    @(negedge clk);
    chk_idle("illegal0");
    opCode = 7'b1011_011;
    @(negedge clk);
    start = 1'b0;
    chk_idle("illegal1");

    // Reset during beat 2 of a 4-register STM
    start = 1'b1; opCode = 7'b1100_000; reg_list = 9'h00F; base_val = 32'h300;
    @(negedge clk);
    start = 1'b0;
    chk("rst beat1 addr", 64'(mem_addr), 64'h300);
    chk("rst beat1 reg", 64'(st_reg), 64'd0);
    @(negedge clk);
    chk("rst beat2 addr", 64'(mem_addr), 64'h304);
    chk("rst beat2 reg", 64'(st_reg), 64'd1);
    chk("rst beat2 we", 64'(mem_write_en), 64'd1);
    #2 rst = 1'b1;
    #1 chk_idle("rst async");
    repeat (3) begin
      @(negedge clk);
      chk("rst hold wb_en", 64'(wb_en), 64'd0);
      chk("rst hold done", 64'(done), 64'd0);
    end
    rst = 1'b0;
    run_vec(10, vecs[1]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
